// File: rtl/cache_line_arbiter_if.sv
// Cache/memory handshake bundle for cache_line_arbiter: icache and dcache
// line requests on one side, the burst-mode physical memory port on the other.
interface cache_line_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // Arbiter view
    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    // Cache and memory side view
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_line_arbiter.sv
// Shares one burst-mode memory port between icache (read) and dcache (read/write),
// moving 256-bit lines as 64-bit beats. Define ARB_ROUND_ROBIN_EN for round-robin priority.
module cache_line_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input logic clk,
    input logic rst_n,
    cache_line_arbiter_if.slave bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              owner_icache;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_nxt;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              d_req;
    logic              grant_d;
    logic              last_beat;

    assign d_req     = bus.d_read | bus.d_write;
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who owned the previous burst; icache after reset so dcache wins the first tie
    logic last_owner_icache;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_owner_icache <= 1'b1;
        else if ((state == I_RD || state == D_RD || state == D_WR) && bus.pmem_resp && last_beat)
            last_owner_icache <= owner_icache;
    end

    assign grant_d = d_req && (!bus.i_read || last_owner_icache);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        line_nxt = line_buf;
        if ((state == I_RD || state == D_RD) && bus.pmem_resp)
            line_nxt[cnt*BEAT_W +: BEAT_W] = bus.pmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            owner_icache  <= 1'b0;
            line_buf      <= '0;
            bus.pmem_addr <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        owner_icache  <= 1'b0;
                        bus.pmem_addr <= {bus.d_addr[ADDR_W-1:5], 5'b0};
                        // A simultaneous read+write is treated as a write
                        if (bus.d_write) begin
                            state    <= D_WR;
                            line_buf <= bus.d_wdata;
                        end else begin
                            state <= D_RD;
                        end
                    end else if (bus.i_read) begin
                        state         <= I_RD;
                        owner_icache  <= 1'b1;
                        bus.pmem_addr <= {bus.i_addr[ADDR_W-1:5], 5'b0};
                    end
                end
                I_RD, D_RD, D_WR: begin
                    if (bus.pmem_resp) begin
                        line_buf <= line_nxt;
                        cnt      <= cnt + 1'b1;
                        if (last_beat) begin
                            state <= DONE;
                            if (owner_icache) i_rdata_q <= line_nxt;
                            else              d_rdata_q <= line_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read  = (state == I_RD) || (state == D_RD);
    assign bus.pmem_write = (state == D_WR);
    assign bus.pmem_wdata = (state == D_WR) ? line_buf[cnt*BEAT_W +: BEAT_W] : '0;
    assign bus.i_resp     = (state == DONE) && owner_icache;
    assign bus.d_resp     = (state == DONE) && !owner_icache;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed self-checking bench for cache_line_arbiter.
module tb_cache_line_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    cache_line_arbiter_if #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) bus ();

    cache_line_arbiter #(.LINE_W(256), .BEAT_W(64), .ADDR_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds four read beats with pmem_resp every cycle; ends in the DONE cycle
    task automatic feed_read(input logic [255:0] line);
        for (int b = 0; b < 4; b++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = line[b*64 +: 64];
            step();
        end
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
    endtask

    task automatic test_reset();
        bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
        rst_n = 0;
        step(); step();
        tests++; if (bus.pmem_read !== 1'b0) begin fails++; $display("FAIL reset_pmem_read got %b want 0", bus.pmem_read); end
        tests++; if (bus.pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_write got %b want 0", bus.pmem_write); end
        tests++; if (bus.pmem_addr !== 32'h0) begin fails++; $display("FAIL reset_pmem_addr got %h want 0", bus.pmem_addr); end
        tests++; if (bus.pmem_wdata !== 64'h0) begin fails++; $display("FAIL reset_pmem_wdata got %h want 0", bus.pmem_wdata); end
        tests++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin fails++; $display("FAIL reset_resp got i=%b d=%b want 0 0", bus.i_resp, bus.d_resp); end
        tests++; if (bus.i_rdata !== 256'h0 || bus.d_rdata !== 256'h0) begin fails++; $display("FAIL reset_rdata got i=%h d=%h want 0", bus.i_rdata, bus.d_rdata); end
        rst_n = 1;
        step(); step();
        tests++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin fails++; $display("FAIL idle_no_req got r=%b w=%b want 0 0", bus.pmem_read, bus.pmem_write); end
    endtask

    task automatic test_icache_read();
        logic [255:0] line;
        line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        bus.i_read = 1; bus.i_addr = 32'h0000_1234;
        step();
        tests++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin fails++; $display("FAIL iread_strobe got r=%b w=%b want 1 0", bus.pmem_read, bus.pmem_write); end
        tests++; if (bus.pmem_addr !== 32'h0000_1220) begin fails++; $display("FAIL iread_addr got %h want 00001220", bus.pmem_addr); end
        feed_read(line);
        tests++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin fails++; $display("FAIL iread_resp got i=%b d=%b want 1 0", bus.i_resp, bus.d_resp); end
        tests++; if (bus.pmem_read !== 1'b0) begin fails++; $display("FAIL iread_done_strobe got %b want 0", bus.pmem_read); end
        tests++; if (bus.i_rdata !== line) begin fails++; $display("FAIL iread_rdata got %h want %h", bus.i_rdata, line); end
        bus.i_read = 0;
        step();
        tests++; if (bus.i_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin fails++; $display("FAIL iread_idle got resp=%b r=%b want 0 0", bus.i_resp, bus.pmem_read); end
        tests++; if (bus.i_rdata !== line) begin fails++; $display("FAIL iread_rdata_hold got %h want %h", bus.i_rdata, line); end
    endtask

    task automatic test_dcache_write();
        logic [255:0] line;
        line = {64'hD0D0D0D0D0D0D0DD, 64'hC0C0C0C0C0C0C0CC, 64'hB0B0B0B0B0B0B0BB, 64'hA0A0A0A0A0A0A0AA};
        bus.d_write = 1; bus.d_addr = 32'h8000_0040; bus.d_wdata = line;
        step();
        bus.d_write = 0; bus.d_wdata = '0;
        tests++; if (bus.pmem_addr !== 32'h8000_0040) begin fails++; $display("FAIL dwrite_addr got %h want 80000040", bus.pmem_addr); end
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) begin
                tests++;
                if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== line[b*64 +: 64] || bus.d_resp !== 1'b0) begin
                    fails++;
                    $display("FAIL dwrite_beat%0d got w=%b r=%b data=%h resp=%b want 1 0 %h 0", b, bus.pmem_write, bus.pmem_read, bus.pmem_wdata, bus.d_resp, line[b*64 +: 64]);
                end
                bus.pmem_resp = (w == 2);
                step();
            end
            bus.pmem_resp = 0;
        end
        tests++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.pmem_write !== 1'b0) begin fails++; $display("FAIL dwrite_resp got d=%b i=%b w=%b want 1 0 0", bus.d_resp, bus.i_resp, bus.pmem_write); end
        step();
        tests++; if (bus.d_resp !== 1'b0) begin fails++; $display("FAIL dwrite_resp_once got %b want 0", bus.d_resp); end
    endtask

    task automatic test_read_write_both();
        bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h0000_2000; bus.d_wdata = {4{64'h5A5A5A5A5A5A5A5A}};
        step();
        bus.d_read = 0; bus.d_write = 0;
        tests++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin fails++; $display("FAIL rw_is_write got w=%b r=%b want 1 0", bus.pmem_write, bus.pmem_read); end
        bus.pmem_resp = 1;
        step(); step(); step(); step();
        bus.pmem_resp = 0;
        tests++; if (bus.d_resp !== 1'b1) begin fails++; $display("FAIL rw_resp got %b want 1", bus.d_resp); end
        step();
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    task automatic test_fixed_priority();
        logic [255:0] dl, il;
        dl = {64'hDD04, 64'hDD03, 64'hDD02, 64'hDD01};
        il = {64'hEE04, 64'hEE03, 64'hEE02, 64'hEE01};
        bus.i_read = 1; bus.i_addr = 32'h0000_3000;
        bus.d_read = 1; bus.d_addr = 32'h0000_4000;
        step();
        tests++; if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_4000) begin fails++; $display("FAIL prio_d_first got r=%b addr=%h want 1 00004000", bus.pmem_read, bus.pmem_addr); end
        feed_read(dl);
        tests++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.d_rdata !== dl) begin fails++; $display("FAIL prio_d_resp got d=%b i=%b data=%h want 1 0 %h", bus.d_resp, bus.i_resp, bus.d_rdata, dl); end
        bus.d_read = 0;
        step();
        tests++; if (bus.pmem_read !== 1'b0) begin fails++; $display("FAIL prio_idle_gap got %b want 0", bus.pmem_read); end
        step();
        tests++; if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_3000) begin fails++; $display("FAIL prio_i_second got r=%b addr=%h want 1 00003000", bus.pmem_read, bus.pmem_addr); end
        feed_read(il);
        tests++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== il) begin fails++; $display("FAIL prio_i_resp got %b data=%h want 1 %h", bus.i_resp, bus.i_rdata, il); end
        bus.i_read = 0;
        step();
    endtask
`else
    task automatic test_round_robin();
        logic [255:0] l;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        bus.i_read = 1; bus.i_addr = 32'h0000_3000;
        bus.d_read = 1; bus.d_addr = 32'h0000_4000;
        for (int k = 0; k < 4; k++) begin
            l = {4{64'h0 + 64'(k + 1)}};
            step();
            tests++;
            if (bus.pmem_addr !== ((k % 2 == 0) ? 32'h0000_4000 : 32'h0000_3000)) begin
                fails++; $display("FAIL rr_grant%0d got addr=%h", k, bus.pmem_addr);
            end
            feed_read(l);
            tests++;
            if (bus.d_resp !== (k % 2 == 0) || bus.i_resp !== (k % 2 == 1)) begin
                fails++; $display("FAIL rr_resp%0d got d=%b i=%b", k, bus.d_resp, bus.i_resp);
            end
            step();
        end
        bus.i_read = 0; bus.d_read = 0;
        step();
    endtask
`endif

    task automatic test_reset_mid_burst();
        logic [255:0] l;
        l = {64'h0F0F000000000004, 64'h0F0F000000000003, 64'h0F0F000000000002, 64'h0F0F000000000001};
        bus.i_read = 1; bus.i_addr = 32'h0000_5000;
        step();
        bus.pmem_resp = 1;
        for (int b = 0; b < 3; b++) begin
            bus.pmem_rdata = 64'hBAD0 + 64'(b);
            step();
        end
        bus.pmem_resp = 0;
        rst_n = 0;
        #1;
        tests++; if (bus.pmem_read !== 1'b0 || bus.pmem_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_strobe got r=%b addr=%h want 0 0", bus.pmem_read, bus.pmem_addr); end
        bus.i_read = 0;
        step();
        tests++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin fails++; $display("FAIL rst_mid_resp got i=%b d=%b want 0 0", bus.i_resp, bus.d_resp); end
        rst_n = 1;
        step();
        bus.d_read = 1; bus.d_addr = 32'h0000_6010;
        step();
        bus.d_read = 0;
        tests++; if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_6000) begin fails++; $display("FAIL rst_restart got r=%b addr=%h want 1 00006000", bus.pmem_read, bus.pmem_addr); end
        feed_read(l);
        tests++; if (bus.d_resp !== 1'b1 || bus.d_rdata !== l) begin fails++; $display("FAIL rst_restart_line got %b %h want 1 %h", bus.d_resp, bus.d_rdata, l); end
        step();
    endtask

    task automatic test_drop_request();
        logic [255:0] l;
        int pulses;
        l = {64'h7777, 64'h6666, 64'h5555, 64'h4444};
        pulses = 0;
        bus.i_read = 1; bus.i_addr = 32'h0000_7000;
        step();
        bus.i_read = 0;
        for (int b = 0; b < 4; b++) begin
            bus.pmem_resp = 1; bus.pmem_rdata = l[b*64 +: 64];
            step();
            if (bus.i_resp === 1'b1) pulses++;
        end
        bus.pmem_resp = 0;
        step();
        if (bus.i_resp === 1'b1) pulses++;
        tests++; if (pulses !== 1) begin fails++; $display("FAIL drop_resp_count got %0d want 1", pulses); end
        tests++; if (bus.i_rdata !== l) begin fails++; $display("FAIL drop_rdata got %h want %h", bus.i_rdata, l); end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_read_write_both();
`ifndef ARB_ROUND_ROBIN_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_reset_mid_burst();
        test_drop_request();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
